// File: rtl/spcpu_exec_front_if.sv
// Bus between the CPU control FSM and the execute front end: the instruction
// and ALU operands going in, and the decoded fields and ALU result coming back.
interface spcpu_exec_front_if;
  logic [15:0] instr_hi;
  logic [3:0]  alu_oper;
  logic [7:0]  a_in_hi;
  logic [7:0]  a_in_lo;
  logic [7:0]  b_in;
  logic [3:0]  proc_flags_in;

  logic [2:0]  group_out;
  logic        instr_is_32_bit;
  logic [2:0]  ig1_opcode;
  logic [3:0]  ig1_ra_index;
  logic [7:0]  ig1_imm_value_8;
  logic        ig1_ra_index_is_for_pair;
  logic [7:0]  out_hi;
  logic [7:0]  out_lo;
  logic [3:0]  proc_flags_out;

  // Control FSM side: supplies instruction/operands, consumes results.
  modport master (
    output instr_hi, alu_oper, a_in_hi, a_in_lo, b_in, proc_flags_in,
    input  group_out, instr_is_32_bit, ig1_opcode, ig1_ra_index,
           ig1_imm_value_8, ig1_ra_index_is_for_pair, out_hi, out_lo,
           proc_flags_out
  );

  // Execute front end side.
  modport slave (
    input  instr_hi, alu_oper, a_in_hi, a_in_lo, b_in, proc_flags_in,
    output group_out, instr_is_32_bit, ig1_opcode, ig1_ra_index,
           ig1_imm_value_8, ig1_ra_index_is_for_pair, out_hi, out_lo,
           proc_flags_out
  );
endinterface

// File: rtl/spcpu_exec_front.sv
// Registered decode + ALU front end of the practice CPU. One result per
// cycle, one cycle of latency; the output registers are the only state.
// Flags are packed {Z,C,V,N} in bits [3:0].
module spcpu_exec_front (
  input  logic               clk,
  input  logic               reset,
  spcpu_exec_front_if.slave  bus
);

  logic [2:0]  grp_d;
  logic        is32_d;
  logic [2:0]  opc_d;
  logic [3:0]  ra_d;
  logic [7:0]  imm_d;
  logic        pair_d;

  logic [7:0]  hi_d;
  logic [7:0]  lo_d;
  logic [3:0]  flags_d;

  logic        c_in;
  logic        v_in;
  logic        c_d;
  logic        v_d;
  logic        wide;
  logic [7:0]  res8;
  logic [15:0] res16;
  logic [8:0]  sum9;
  logic [16:0] sum17;
  logic [15:0] pair_a;
  logic [15:0] b_ext;

  // Instruction group classification and group-1 field extraction.
  always_comb begin
    grp_d  = 3'd0;
    opc_d  = 3'd0;
    ra_d   = 4'd0;
    imm_d  = 8'd0;
    pair_d = 1'b0;
    casez (bus.instr_hi[15:12])
      4'b0???: grp_d = 3'd1;
      4'b100?: grp_d = 3'd2;
      4'b101?: grp_d = 3'd3;
      4'b110?: grp_d = 3'd4;
      4'b1110: grp_d = 3'd5;
      default: grp_d = 3'd0;
    endcase
    if (grp_d == 3'd1) begin
      opc_d = bus.instr_hi[14:12];
      ra_d  = bus.instr_hi[11:8];
      imm_d = bus.instr_hi[7:0];
      // addpi targets a register pair, always named by its even register.
      if (opc_d == 3'd6) begin
        pair_d  = 1'b1;
        ra_d[0] = 1'b0;
      end
    end
    is32_d = (grp_d == 3'd5);
  end

  // ALU: 8-bit ops on a_in_lo/b_in with a_in_hi passed through, plus the two
  // 16-bit pair ops. Carry on subtracts is a borrow, taken from the 9th/17th bit.
  always_comb begin
    c_in   = bus.proc_flags_in[2];
    v_in   = bus.proc_flags_in[1];
    c_d    = c_in;
    v_d    = v_in;
    wide   = 1'b0;
    res8   = 8'd0;
    res16  = 16'd0;
    sum9   = 9'd0;
    sum17  = 17'd0;
    pair_a = {bus.a_in_hi, bus.a_in_lo};
    b_ext  = {{8{bus.b_in[7]}}, bus.b_in};
    hi_d   = bus.a_in_hi;
    lo_d   = 8'd0;
    case (bus.alu_oper)
      4'd0, 4'd1: begin
        sum9 = {1'b0, bus.a_in_lo} + {1'b0, bus.b_in}
             + {8'd0, (bus.alu_oper == 4'd1) & c_in};
        res8 = sum9[7:0];
        c_d  = sum9[8];
        v_d  = (bus.a_in_lo[7] == bus.b_in[7]) && (res8[7] != bus.a_in_lo[7]);
      end
      4'd2, 4'd3, 4'd4: begin
        sum9 = {1'b0, bus.a_in_lo} - {1'b0, bus.b_in}
             - {8'd0, (bus.alu_oper == 4'd3) & c_in};
        res8 = sum9[7:0];
        c_d  = sum9[8];
        v_d  = (bus.a_in_lo[7] != bus.b_in[7]) && (res8[7] != bus.a_in_lo[7]);
      end
      4'd5:  res8 = bus.a_in_lo & bus.b_in;
      4'd6:  res8 = bus.a_in_lo | bus.b_in;
      4'd7:  res8 = bus.a_in_lo ^ bus.b_in;
      4'd8:  begin res8 = {bus.a_in_lo[6:0], 1'b0};           c_d = bus.a_in_lo[7]; end
      4'd9:  begin res8 = {1'b0, bus.a_in_lo[7:1]};           c_d = bus.a_in_lo[0]; end
      4'd10: begin res8 = {bus.a_in_lo[7], bus.a_in_lo[7:1]}; c_d = bus.a_in_lo[0]; end
      4'd11: begin res8 = {bus.a_in_lo[6:0], c_in};           c_d = bus.a_in_lo[7]; end
      4'd12: begin res8 = {c_in, bus.a_in_lo[7:1]};           c_d = bus.a_in_lo[0]; end
      4'd13: res8 = bus.b_in;
      4'd14: begin
        wide  = 1'b1;
        sum17 = {1'b0, pair_a} + {1'b0, b_ext};
        res16 = sum17[15:0];
        c_d   = sum17[16];
        v_d   = (pair_a[15] == b_ext[15]) && (res16[15] != pair_a[15]);
      end
      default: begin
        wide  = 1'b1;
        sum17 = {1'b0, pair_a} - {1'b0, b_ext};
        res16 = sum17[15:0];
        c_d   = sum17[16];
        v_d   = (pair_a[15] != b_ext[15]) && (res16[15] != pair_a[15]);
      end
    endcase
    if (wide) begin
      hi_d    = res16[15:8];
      lo_d    = res16[7:0];
      flags_d = {(res16 == 16'd0), c_d, v_d, res16[15]};
    end else begin
      // cmp keeps operand A on the output; its flags still come from a-b.
      lo_d    = (bus.alu_oper == 4'd4) ? bus.a_in_lo : res8;
      flags_d = {(res8 == 8'd0), c_d, v_d, res8[7]};
    end
  end

  // Output registers; reset clears everything regardless of inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.group_out                <= 3'd0;
      bus.instr_is_32_bit          <= 1'b0;
      bus.ig1_opcode               <= 3'd0;
      bus.ig1_ra_index             <= 4'd0;
      bus.ig1_imm_value_8          <= 8'd0;
      bus.ig1_ra_index_is_for_pair <= 1'b0;
      bus.out_hi                   <= 8'd0;
      bus.out_lo                   <= 8'd0;
      bus.proc_flags_out           <= 4'd0;
    end else begin
      bus.group_out                <= grp_d;
      bus.instr_is_32_bit          <= is32_d;
      bus.ig1_opcode               <= opc_d;
      bus.ig1_ra_index             <= ra_d;
      bus.ig1_imm_value_8          <= imm_d;
      bus.ig1_ra_index_is_for_pair <= pair_d;
      bus.out_hi                   <= hi_d;
      bus.out_lo                   <= lo_d;
      bus.proc_flags_out           <= flags_d;
    end
  end

endmodule

// File: tb/tb_spcpu_exec_front.sv
// Bench for spcpu_exec_front: directed test-plan steps with hand-computed
// expectations, then randomized steps checked against an integer-arithmetic
// reference model.
module tb_spcpu_exec_front;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  spcpu_exec_front_if bus_if ();

  spcpu_exec_front dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sgn8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic int sgn16(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // {group[2:0], is32, opcode[2:0], ra[3:0], imm[7:0], pair}
  function automatic logic [19:0] dec_model(input int instr);
    int grp, opc, ra, imm, pair;
    grp = 0; opc = 0; ra = 0; imm = 0; pair = 0;
    if (instr < 'h8000)      grp = 1;
    else if (instr < 'hA000) grp = 2;
    else if (instr < 'hC000) grp = 3;
    else if (instr < 'hE000) grp = 4;
    else if (instr < 'hF000) grp = 5;
    if (grp == 1) begin
      opc = (instr / 4096) % 8;
      ra  = (instr / 256) % 16;
      imm = instr % 256;
      if (opc == 6) begin pair = 1; ra = ra - (ra % 2); end
    end
    return {grp[2:0], (grp == 5), opc[2:0], ra[3:0], imm[7:0], pair[0]};
  endfunction

  // {out_hi, out_lo, flags{Z,C,V,N}}
  function automatic logic [19:0] alu_model(input int op, input int ahi, input int alo,
                                            input int b, input int f);
    int c, v, r, s, hi, lo, fr, p, sb, z, n, cc, vv, wide;
    c = (f / 4) % 2; v = (f / 2) % 2;
    cc = c; vv = v; hi = ahi; lo = 0; fr = 0; wide = 0; z = 0; n = 0;
    case (op)
      0, 1: begin
        r = alo + b + ((op == 1) ? c : 0);
        s = sgn8(alo) + sgn8(b) + ((op == 1) ? c : 0);
        fr = r % 256; lo = fr; cc = (r > 255); vv = (s > 127 || s < -128);
      end
      2, 3, 4: begin
        r = alo - b - ((op == 3) ? c : 0);
        s = sgn8(alo) - sgn8(b) - ((op == 3) ? c : 0);
        fr = (r + 256) % 256; lo = (op == 4) ? alo : fr;
        cc = (r < 0); vv = (s > 127 || s < -128);
      end
      5:  begin fr = alo & b; lo = fr; end
      6:  begin fr = alo | b; lo = fr; end
      7:  begin fr = alo ^ b; lo = fr; end
      8:  begin fr = (alo * 2) % 256; lo = fr; cc = (alo >= 128); end
      9:  begin fr = alo / 2; lo = fr; cc = alo % 2; end
      10: begin fr = alo / 2 + ((alo >= 128) ? 128 : 0); lo = fr; cc = alo % 2; end
      11: begin fr = (alo * 2) % 256 + c; lo = fr; cc = (alo >= 128); end
      12: begin fr = alo / 2 + c * 128; lo = fr; cc = alo % 2; end
      13: begin fr = b; lo = fr; end
      default: begin
        wide = 1;
        p  = ahi * 256 + alo;
        sb = sgn8(b);
        if (op == 14) begin
          r = p + (sb & 'hFFFF); cc = (r > 65535); s = sgn16(p) + sb;
        end else begin
          r = p - (sb & 'hFFFF); cc = (r < 0);     s = sgn16(p) - sb;
        end
        vv = (s > 32767 || s < -32768);
        fr = (r + 65536) % 65536;
        hi = fr / 256; lo = fr % 256;
      end
    endcase
    if (wide) begin z = (fr == 0); n = (fr >= 32768); end
    else      begin z = (fr == 0); n = (fr >= 128);   end
    return {hi[7:0], lo[7:0], z[0], cc[0], vv[0], n[0]};
  endfunction

  task automatic drive(input logic rst, input logic [15:0] instr, input logic [3:0] op,
                       input logic [7:0] ahi, input logic [7:0] alo, input logic [7:0] b,
                       input logic [3:0] f);
    reset                = rst;
    bus_if.instr_hi      = instr;
    bus_if.alu_oper      = op;
    bus_if.a_in_hi       = ahi;
    bus_if.a_in_lo       = alo;
    bus_if.b_in          = b;
    bus_if.proc_flags_in = f;
  endtask

  // Apply one cycle of inputs and compare every output with the model.
  task automatic step(input logic rst, input logic [15:0] instr, input logic [3:0] op,
                      input logic [7:0] ahi, input logic [7:0] alo, input logic [7:0] b,
                      input logic [3:0] f);
    logic [19:0] d, a;
    drive(rst, instr, op, ahi, alo, b, f);
    if (rst) begin
      d = 20'd0; a = 20'd0;
    end else begin
      d = dec_model(int'(instr));
      a = alu_model(int'(op), int'(ahi), int'(alo), int'(b), int'(f));
    end
    @(posedge clk); #1;
    chk("group",  16'(bus_if.group_out),                d[19:17]);
    chk("is32",   16'(bus_if.instr_is_32_bit),          d[16]);
    chk("opcode", 16'(bus_if.ig1_opcode),               d[15:13]);
    chk("ra",     16'(bus_if.ig1_ra_index),             d[12:9]);
    chk("imm",    16'(bus_if.ig1_imm_value_8),          d[8:1]);
    chk("pair",   16'(bus_if.ig1_ra_index_is_for_pair), d[0]);
    chk("out_hi", 16'(bus_if.out_hi),                   a[19:12]);
    chk("out_lo", 16'(bus_if.out_lo),                   a[11:4]);
    chk("flags",  16'(bus_if.proc_flags_out),           a[3:0]);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 16'h0000, 4'd0, 8'h00, 8'h00, 8'h00, 4'h0);
    step(1'b1, 16'h1234, 4'd3, 8'h55, 8'hAA, 8'h11, 4'hF);
    chk("rst_group", 16'(bus_if.group_out), 16'd0);

    step(1'b0, 16'h0000, 4'd0, 8'h00, 8'h7F, 8'h01, 4'h0);
    chk("add_lo", 16'(bus_if.out_lo), 16'h80);
    chk("add_fl", 16'(bus_if.proc_flags_out), 16'b0011);

    step(1'b0, 16'h0000, 4'd2, 8'h00, 8'h00, 8'h01, 4'h0);
    chk("sub_lo", 16'(bus_if.out_lo), 16'hFF);
    chk("sub_fl", 16'(bus_if.proc_flags_out), 16'b0101);

    step(1'b0, 16'h0000, 4'd3, 8'h00, 8'h05, 8'h05, 4'b0100);
    chk("sbc_lo", 16'(bus_if.out_lo), 16'hFF);
    chk("sbc_fl", 16'(bus_if.proc_flags_out), 16'b0101);

    step(1'b0, 16'h0000, 4'd4, 8'h00, 8'h10, 8'h10, 4'h0);
    chk("cmp_lo", 16'(bus_if.out_lo), 16'h10);
    chk("cmp_fl", 16'(bus_if.proc_flags_out), 16'b1000);

    step(1'b0, 16'h0000, 4'd14, 8'h00, 8'hFF, 8'h01, 4'h0);
    chk("addp1", {bus_if.out_hi, bus_if.out_lo}, 16'h0100);
    chk("addp1_fl", 16'(bus_if.proc_flags_out), 16'b0000);

    step(1'b0, 16'h0000, 4'd14, 8'h00, 8'h00, 8'hFF, 4'h0);
    chk("addp2", {bus_if.out_hi, bus_if.out_lo}, 16'hFFFF);
    chk("addp2_fl", 16'(bus_if.proc_flags_out), 16'b0001);

    step(1'b0, 16'h0000, 4'd11, 8'h00, 8'h81, 8'h00, 4'h0);
    chk("rolc_lo", 16'(bus_if.out_lo), 16'h02);
    chk("rolc_fl", 16'(bus_if.proc_flags_out), 16'b0100);

    step(1'b0, 16'h0000, 4'd5, 8'h00, 8'hF0, 8'h0F, 4'b0110);
    chk("and_fl", 16'(bus_if.proc_flags_out), 16'b1110);

    step(1'b0, 16'h5A3C, 4'd0, 8'h00, 8'h00, 8'h00, 4'h0);
    chk("dec1", {bus_if.group_out, bus_if.ig1_opcode, bus_if.ig1_ra_index,
                 bus_if.ig1_ra_index_is_for_pair, 5'd0}, {3'd1, 3'd5, 4'hA, 1'b0, 5'd0});
    chk("dec1_imm", 16'(bus_if.ig1_imm_value_8), 16'h3C);

    step(1'b0, 16'h6F05, 4'd0, 8'h00, 8'h00, 8'h00, 4'h0);
    chk("dec2", {bus_if.ig1_opcode, bus_if.ig1_ra_index, bus_if.ig1_ra_index_is_for_pair, 8'd0},
                {3'd6, 4'hE, 1'b1, 8'd0});

    step(1'b0, 16'hE000, 4'd0, 8'h00, 8'h00, 8'h00, 4'h0);
    chk("dec_g5", {bus_if.group_out, bus_if.instr_is_32_bit, bus_if.ig1_opcode, 9'd0},
                  {3'd5, 1'b1, 3'd0, 9'd0});

    step(1'b0, 16'hF123, 4'd0, 8'h00, 8'h00, 8'h00, 4'h0);
    chk("dec_unk", 16'(bus_if.group_out), 16'd0);

    step(1'b1, 16'h5A3C, 4'd14, 8'h12, 8'h34, 8'h56, 4'hF);
    chk("rst_mid", {bus_if.out_hi, bus_if.out_lo}, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), 16'($urandom), 4'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
